// File: rtl/learning_neuron.sv
// learning_neuron: single neuron with registered output, per-input error back-propagation and online weight/bias learning
// Ports: clk; rst (async, active-high); in[NUM_INPUTS] signed inputs; backpropStart error for registered out;
//        learnRate signed rate; learnShift update right-shift ([5:0]); back[NUM_INPUTS] propagated error; out neuron output.
// Config: define NEURON_RELU_EN for ReLU activation, otherwise identity.
module learning_neuron #(
   parameter int NUM_INPUTS  = 32,
   parameter int WIDTH       = 32,
   parameter int INIT_WEIGHT = 8
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [NUM_INPUTS-1:0][WIDTH-1:0]     in,
   input  logic [WIDTH-1:0]                     backpropStart,
   input  logic [WIDTH-1:0]                     learnRate,
   input  logic [WIDTH-1:0]                     learnShift,
   output logic [NUM_INPUTS-1:0][WIDTH-1:0]     back,
   output logic [WIDTH-1:0]                     out
);
   localparam int W2 = 2 * WIDTH;
   function automatic logic signed [W2-1:0] sx(input logic signed [WIDTH-1:0] v);
      return v;
   endfunction
   logic [NUM_INPUTS-1:0][WIDTH-1:0] w_q, w_d, in_q, back_q, back_d;
   logic [WIDTH-1:0] b_q, b_d, out_q, out_d;
   logic act_q, act_d;
   logic signed [W2-1:0] pre, err, rate, tw, tb;
   logic [5:0] sh;
   logic unused_shift_bits;
   assign unused_shift_bits = ^learnShift[WIDTH-1:6];
   assign sh = learnShift[5:0];
   always_comb begin
      err = sx(backpropStart);
      rate = sx(learnRate);
      pre = sx(b_q);
      tw = '0;
      back_d = '0;
      w_d = w_q;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         pre = pre + sx(in[i]) * sx(w_q[i]);
         tw = (err * sx(in_q[i]) * rate) >>> sh;
         back_d[i] = act_q ? WIDTH'(err * sx(w_q[i])) : '0;
         w_d[i] = act_q ? w_q[i] - tw[WIDTH-1:0] : w_q[i];
      end
      tb = (err * rate) >>> sh;
      b_d = act_q ? b_q - tb[WIDTH-1:0] : b_q;
`ifdef NEURON_RELU_EN
      act_d = ~pre[W2-1];
      out_d = act_d ? pre[WIDTH-1:0] : '0;
`else
      act_d = 1'b1;
      out_d = pre[WIDTH-1:0];
`endif
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_q <= {NUM_INPUTS{WIDTH'(INIT_WEIGHT)}};
         b_q <= WIDTH'(INIT_WEIGHT);
         in_q <= '0;
         back_q <= '0;
         out_q <= '0;
         act_q <= 1'b1;
      end else begin
         w_q <= w_d;
         b_q <= b_d;
         in_q <= in;
         back_q <= back_d;
         out_q <= out_d;
         act_q <= act_d;
      end
   end
   assign back = back_q;
   assign out = out_q;
endmodule

// File: tb/tb_learning_neuron.sv
// tb_learning_neuron: directed self-checking bench for learning_neuron
module tb_learning_neuron;
   localparam int N = 32;
   localparam int W = 32;
   logic clk = 1'b0;
   logic rst;
   logic [N-1:0][W-1:0] in_v, back_v;
   logic [W-1:0] err_v, rate_v, shift_v, out_v;
   int total = 0;
   int bad = 0;
   learning_neuron #(.NUM_INPUTS(N), .WIDTH(W), .INIT_WEIGHT(8)) dut (
      .clk(clk), .rst(rst), .in(in_v), .backpropStart(err_v), .learnRate(rate_v),
      .learnShift(shift_v), .back(back_v), .out(out_v)
   );
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic chk_back(input string tag, input logic [W-1:0] exp);
      logic [N-1:0][W-1:0] e;
      e = {N{exp}};
      total++;
      assert (back_v === e) else begin
         bad++;
         $error("FAIL %s: got back[0]=%0h back[%0d]=%0h expected all %0h", tag, back_v[0], N-1, back_v[N-1], exp);
      end
   endtask
   initial begin
      rst = 1'b1;
      in_v = '0;
      err_v = '0;
      rate_v = '0;
      shift_v = '0;
      tick();
      chk("reset_out", out_v, 32'd0);
      chk_back("reset_back", 32'd0);
      rst = 1'b0;
      tick();
      chk("init_bias_out", out_v, 32'd8);
      // all ones, no error: 32*8+8
      in_v = {N{32'd1}};
      rate_v = 32'd1;
      tick();
      chk("ones_out", out_v, 32'd264);
      chk_back("ones_back", 32'd0);
      tick();
      chk("ones_out_stable", out_v, 32'd264);
      in_v = '0;
      tick();
      chk("zero_in_out", out_v, 32'd8);
      // bias learning with err=1
      err_v = 32'd1;
      tick();
      chk("bias_e1", out_v, 32'd8);
      chk_back("back_e1", 32'd8);
      tick();
      chk("bias_e2", out_v, 32'd7);
      tick();
      chk("bias_e3", out_v, 32'd6);
      chk_back("back_e3", 32'd8);
      // weight learning on w[0] with shift 1 (bias now 5, delta 0)
      in_v[0] = 32'd2;
      shift_v = 32'd1;
      tick();
      chk("w0_e1_out", out_v, 32'd21);
      chk("w0_e1_back0", back_v[0], 32'd8);
      tick();
      chk("w0_e2_out", out_v, 32'd21);
      chk("w0_e2_back0", back_v[0], 32'd8);
      tick();
      chk("w0_e3_out", out_v, 32'd19);
      chk("w0_e3_back0", back_v[0], 32'd7);
      chk("w0_e3_back1", back_v[1], 32'd8);
      tick();
      chk("w0_e4_out", out_v, 32'd17);
      chk("w0_e4_back0", back_v[0], 32'd6);
      // w0=5, others 8, b=5
      err_v = '0;
      shift_v = '0;
      in_v = {N{32'd1}};
      tick();
      chk("weights_sum", out_v, 32'd258);
      // shift field 64 -> [5:0]=0, err=-1 raises bias
      in_v = '0;
      err_v = 32'hFFFF_FFFF;
      shift_v = 32'd64;
      tick();
      chk("neg_err_e1", out_v, 32'd5);
      chk("neg_err_back0", back_v[0], 32'hFFFF_FFFB);
      tick();
      chk("neg_err_e2", out_v, 32'd6);
      tick();
      chk("neg_err_e3", out_v, 32'd7);
      // asynchronous reset mid-run
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_out", out_v, 32'd0);
      chk_back("async_rst_back", 32'd0);
      tick();
      rst = 1'b0;
      err_v = '0;
      shift_v = '0;
      tick();
      chk("post_rst_out", out_v, 32'd8);
      in_v = {N{32'd1}};
      tick();
      chk("post_rst_weights", out_v, 32'd264);
      in_v = '0;
      tick();
      chk("post_rst_bias", out_v, 32'd8);
      // negative pre-activation
      in_v[0] = 32'hFFFF_FF9C;
      err_v = 32'd1;
      tick();
`ifdef NEURON_RELU_EN
      chk("neg_pre_out", out_v, 32'd0);
      chk_back("neg_pre_back", 32'd8);
      tick();
      chk("relu_gate_out", out_v, 32'd0);
      chk_back("relu_gate_back", 32'd0);
      in_v = '0;
      err_v = '0;
      tick();
      chk("relu_frozen_bias", out_v, 32'd7);
      in_v[0] = 32'd1;
      tick();
      chk("relu_frozen_w0", out_v, 32'd15);
`else
      chk("neg_pre_out", out_v, 32'hFFFF_FCE8);
      chk_back("neg_pre_back", 32'd8);
      tick();
      chk("ident_e2_out", out_v, 32'hFFFF_FCE7);
      chk_back("ident_e2_back", 32'd8);
      in_v = '0;
      err_v = '0;
      tick();
      chk("ident_bias", out_v, 32'd6);
      in_v[0] = 32'd1;
      tick();
      chk("ident_w0", out_v, 32'd114);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/learning_neuron.md
LEARNING_NEURON -- requirements
Module: learning_neuron

Interface
REQ-001 Parameter NUM_INPUTS, default 32, number of synaptic inputs.
REQ-002 Parameter WIDTH, default 32, data/weight width, signed two's complement.
REQ-003 Parameter INIT_WEIGHT, default 8, reset value of every weight and of the bias.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in  input  NUM_INPUTS x WIDTH  packed array of signed inputs, in[i] for i = 0..NUM_INPUTS-1.
REQ-007 backpropStart  input  WIDTH  signed error term err = dLoss/dout for the currently registered out.
REQ-008 learnRate  input  WIDTH  signed learning-rate multiplier.
REQ-009 learnShift  input  WIDTH  right-shift amount applied to updates; only bits [5:0] used.
REQ-010 back  output  NUM_INPUTS x WIDTH  registered error propagated to each input.
REQ-011 out  output  WIDTH  registered neuron output.

Function
REQ-012 State: weights w[0..NUM_INPUTS-1], bias b, input register in_q[0..NUM_INPUTS-1], flag act_q.
REQ-013 Each edge: pre = sum(in[i]*w[i]) + b, using weights before this edge's update; products and sum in 2*WIDTH signed, wrapping.
REQ-014 Each edge: out <= low WIDTH bits of pre after activation; in_q <= in; act_q <= 1 when the activation passes pre.
REQ-015 Latency: out reflects in sampled one edge earlier.
REQ-016 Each edge: back[i] <= low WIDTH bits of err*w[i] (pre-update w[i]) when act_q=1, else 0.
REQ-017 Each edge: w[i] <= w[i] - low WIDTH bits of ((err*in_q[i]*learnRate) >>> learnShift[5:0]) when act_q=1; 2*WIDTH signed intermediate, arithmetic shift.
REQ-018 Each edge: b <= b - low WIDTH bits of ((err*learnRate) >>> learnShift[5:0]) when act_q=1.
REQ-019 err=0, learnRate=0 or act_q=0 leaves all weights and bias unchanged.
REQ-020 Weight/bias arithmetic wraps modulo 2^WIDTH; no saturation.
REQ-021 Shift >= 2*WIDTH yields 0 for non-negative and -1 for negative intermediates.

Reset
REQ-022 While rst=1: out=0, back all 0, w[i]=b=INIT_WEIGHT, in_q all 0, act_q=1; takes effect immediately, independent of clk.
REQ-023 Reset asserted mid-training discards all learned weights; first edge after release computes with INIT_WEIGHT.

Configuration
REQ-024 Macro NEURON_RELU_EN defined: activation is ReLU; negative pre gives out=0 and act_q=0, gating REQ-016..018 on the next edge.
REQ-025 Macro NEURON_RELU_EN undefined: activation is identity; out = pre truncated, act_q always 1.

Verification
REQ-026 rst=1 mid-run -> out=0, back all 0 immediately; release, in all 0, err=0 -> out=8 after first edge.
REQ-027 in all 1, err=0, rate=1, shift=0 -> out=264 (32*8+8) one edge later; back all 0; weights stay 8.
REQ-028 in all 0, err=1, rate=1, shift=0 -> back[i]=8 after first edge; b decrements 8,7,6 per edge; out tracks b one edge later.
REQ-029 in[0]=2, others 0, err=1, rate=1, shift=1 -> from second edge w[0] decrements by 1 per edge; other weights stay 8; err=1, shift=1 gives bias delta 0.
REQ-030 in[0]=0xFFFFFF9C (-100), others 0, err=1, rate=1, shift=0: macro defined -> out=0, back all 0, weights frozen next edge; macro undefined -> out=0xFFFFFCE8 (-792).
REQ-031 learnShift=64, err=-1, rate=1, in all 0 -> bias increments by 1 per edge (-1 shift result).
